// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU retire-trace emitter: FSM state encoding,
// ASCII constants of the trace line grammar and small character helpers.
// Optional feature macro: CPU_TRACE_SPACES_EN (adds the three single spaces).
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CARET = 4'd1,
    ST_TIME  = 4'd2,
    ST_AT    = 4'd3,
    ST_PC    = 4'd4,
    ST_COLON = 4'd5,
    ST_SP1   = 4'd6,
    ST_MARK  = 4'd7,
    ST_REG   = 4'd8,
    ST_ADDR  = 4'd9,
    ST_SP2   = 4'd10,
    ST_LT    = 4'd11,
    ST_EQ    = 4'd12,
    ST_SP3   = 4'd13,
    ST_DATA  = 4'd14,
    ST_HASH  = 4'd15
  } trace_state_e;

  localparam logic [7:0] CH_NUL    = 8'h00;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;

  // Nibble idx of a 32-bit word, idx 0 being the least significant nibble.
  function automatic logic [3:0] nibble_of(input logic [31:0] w, input logic [2:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

  // BCD digit idx of the time field (idx 0 = most significant), clamped to '9'.
  function automatic logic [7:0] time_digit(input logic [15:0] t, input logic [1:0] idx);
    logic [3:0] nib;
    nib = t[{~idx, 2'b00} +: 4];
    return (nib > 4'd9) ? CH_NINE : {4'h3, nib};
  endfunction

  // Tens digit of a register number 0-31.
  function automatic logic [1:0] reg_tens(input logic [4:0] r);
    if (r >= 5'd30)      return 2'd3;
    else if (r >= 5'd20) return 2'd2;
    else if (r >= 5'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  // Ones digit of a register number 0-31 as ASCII.
  function automatic logic [7:0] reg_ones_char(input logic [4:0] r);
    logic [4:0] ones;
    case (reg_tens(r))
      2'd3:    ones = r - 5'd30;
      2'd2:    ones = r - 5'd20;
      2'd1:    ones = r - 5'd10;
      default: ones = r;
    endcase
    return CH_ZERO + {3'b000, ones};
  endfunction

endpackage

// File: rtl/trace_hex_ascii.sv
// Converts one 4-bit nibble into its lowercase ASCII hex character.
module trace_hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // '0'-'9' for 0-9, 'a'-'f' for 10-15.
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises CPU retire events into ASCII trace lines, one character per
// cycle: "^T@P: $R <= D#" for register writes, "^T@P: *A <= D#" for memory
// writes. Spaces are present only when CPU_TRACE_SPACES_EN is defined.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic        ev_is_mem,
  input  logic [15:0] ev_time_bcd,
  input  logic [31:0] ev_pc,
  input  logic [4:0]  ev_reg,
  input  logic [31:0] ev_addr,
  input  logic [31:0] ev_data,
  output logic [7:0]  char,
  output logic        char_valid
);

`ifdef CPU_TRACE_SPACES_EN
  localparam bit SPACES_EN = 1'b1;
`else
  localparam bit SPACES_EN = 1'b0;
`endif

  trace_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   char_q, char_d;
  logic         char_valid_q, char_valid_d;
  logic         is_mem_q, is_mem_d;
  logic [15:0]  time_q, time_d;
  logic [31:0]  pc_q, pc_d;
  logic [4:0]   reg_q, reg_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;

  logic         accept;
  logic [1:0]   time_start;
  logic [31:0]  hex_word;
  logic [2:0]   hex_idx;
  logic [3:0]   hex_nib;
  logic [7:0]   hex_char;
  logic [7:0]   mark_char;
  logic [7:0]   reg_first_char;

  assign ev_ready   = (state_q == ST_IDLE) || (state_q == ST_HASH);
  assign accept     = ev_valid && ev_ready;
  assign char       = char_q;
  assign char_valid = char_valid_q;

  assign mark_char      = is_mem_q ? CH_STAR : CH_DOLLAR;
  assign reg_first_char = (reg_tens(reg_q) != 2'd0) ? (CH_ZERO + {6'd0, reg_tens(reg_q)})
                                                     : reg_ones_char(reg_q);

  // First time digit to print: skip leading zeros but always keep the last digit.
  always_comb begin
    if (time_q[15:12] != 4'd0)     time_start = 2'd0;
    else if (time_q[11:8] != 4'd0) time_start = 2'd1;
    else if (time_q[7:4] != 4'd0)  time_start = 2'd2;
    else                           time_start = 2'd3;
  end

  // Pick the nibble the shared hex converter must render for the next character.
  always_comb begin
    hex_word = data_q;
    hex_idx  = 3'd7;
    case (state_q)
      ST_AT:   begin hex_word = pc_q;   hex_idx = 3'd7;         end
      ST_PC:   begin hex_word = pc_q;   hex_idx = 3'd6 - cnt_q; end
      ST_MARK: begin hex_word = addr_q; hex_idx = 3'd7;         end
      ST_ADDR: begin hex_word = addr_q; hex_idx = 3'd6 - cnt_q; end
      ST_DATA: begin hex_word = data_q; hex_idx = 3'd6 - cnt_q; end
      default: begin hex_word = data_q; hex_idx = 3'd7;         end
    endcase
    hex_nib = nibble_of(hex_word, hex_idx);
  end

  trace_hex_ascii u_hex (
    .nibble (hex_nib),
    .ascii  (hex_char)
  );

  // Next state, next character and event capture; state names the char on the wire.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    char_d       = CH_NUL;
    char_valid_d = 1'b1;
    is_mem_d     = is_mem_q;
    time_d       = time_q;
    pc_d         = pc_q;
    reg_d        = reg_q;
    addr_d       = addr_q;
    data_d       = data_q;

    if (accept) begin
      is_mem_d = ev_is_mem;
      time_d   = ev_time_bcd;
      pc_d     = ev_pc;
      reg_d    = ev_reg;
      addr_d   = ev_addr;
      data_d   = ev_data;
    end

    case (state_q)
      ST_IDLE, ST_HASH: begin
        if (accept) begin
          state_d = ST_CARET;
          char_d  = CH_CARET;
        end else begin
          state_d      = ST_IDLE;
          char_valid_d = 1'b0;
        end
      end
      ST_CARET: begin
        state_d = ST_TIME;
        cnt_d   = 3'd0;
        char_d  = time_digit(time_q, time_start);
      end
      ST_TIME: begin
        if (cnt_q[1:0] == (2'd3 - time_start)) begin
          state_d = ST_AT;
          char_d  = CH_AT;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          char_d = time_digit(time_q, time_start + cnt_q[1:0] + 2'd1);
        end
      end
      ST_AT: begin
        state_d = ST_PC;
        cnt_d   = 3'd0;
        char_d  = hex_char;
      end
      ST_PC: begin
        if (cnt_q == 3'd7) begin
          state_d = ST_COLON;
          char_d  = CH_COLON;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          char_d = hex_char;
        end
      end
      ST_COLON: begin
        if (SPACES_EN) begin
          state_d = ST_SP1;
          char_d  = CH_SPACE;
        end else begin
          state_d = ST_MARK;
          char_d  = mark_char;
        end
      end
      ST_SP1: begin
        state_d = ST_MARK;
        char_d  = mark_char;
      end
      ST_MARK: begin
        cnt_d = 3'd0;
        if (is_mem_q) begin
          state_d = ST_ADDR;
          char_d  = hex_char;
        end else begin
          state_d = ST_REG;
          char_d  = reg_first_char;
        end
      end
      ST_REG, ST_ADDR: begin
        if ((state_q == ST_REG && reg_q >= 5'd10 && cnt_q == 3'd0) ||
            (state_q == ST_ADDR && cnt_q != 3'd7)) begin
          cnt_d  = cnt_q + 3'd1;
          char_d = (state_q == ST_REG) ? reg_ones_char(reg_q) : hex_char;
        end else if (SPACES_EN) begin
          state_d = ST_SP2;
          char_d  = CH_SPACE;
        end else begin
          state_d = ST_LT;
          char_d  = CH_LT;
        end
      end
      ST_SP2: begin
        state_d = ST_LT;
        char_d  = CH_LT;
      end
      ST_LT: begin
        state_d = ST_EQ;
        char_d  = CH_EQ;
      end
      ST_EQ: begin
        if (SPACES_EN) begin
          state_d = ST_SP3;
          char_d  = CH_SPACE;
        end else begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
          char_d  = hex_char;
        end
      end
      ST_SP3: begin
        state_d = ST_DATA;
        cnt_d   = 3'd0;
        char_d  = hex_char;
      end
      ST_DATA: begin
        if (cnt_q == 3'd7) begin
          state_d = ST_HASH;
          char_d  = CH_HASH;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          char_d = hex_char;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = 3'd0;
        char_valid_d = 1'b0;
      end
    endcase
  end

  // Register FSM, outputs and captured event; reset drops any line in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      char_q       <= CH_NUL;
      char_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      is_mem_q     <= is_mem_d;
      time_q       <= time_d;
      pc_q         <= pc_d;
      reg_q        <= reg_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

endmodule
